sad_min_search: RTL

//  Downstream of the PE-column systolic array in inter prediction. Each ad_valid cycle it takes the packed

---
 rtl/me_pkg.sv | 18 +
 rtl/sad_col_tree.sv | 24 ++
 rtl/sad_min_search.sv | 129 ++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared motion-estimation types and width helpers for the SAD search datapath.
package me_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} me_state_t;

  function automatic int sad_w(input int macro_dim);
    return $clog2(macro_dim * macro_dim * 255 + 1);
  endfunction

  function automatic int col_w(input int macro_dim);
    return $clog2(macro_dim * 255 + 1);
  endfunction

  function automatic int mv_w(input int search_range);
    return $clog2(search_range) + 1;
  endfunction

endpackage

// File: rtl/sad_col_tree.sv
// Registered sum of N unsigned IN_W-bit operands; one pipeline stage of the SAD reduction.
module sad_col_tree #(
  parameter int N     = 16,
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*IN_W-1:0] in_vec,
  output logic [OUT_W-1:0]  sum_q
);

  logic [OUT_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) sum_d = sum_d + OUT_W'(in_vec[i*IN_W +: IN_W]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;

endmodule

// File: rtl/sad_min_search.sv
// SAD reduction of PE-array differences and minimum tracking over the full search window.
module sad_min_search
  import me_pkg::*;
#(
  parameter  int MACRO_DIM    = 16,
  parameter  int SEARCH_RANGE = 16,
  localparam int SAD_W        = sad_w(MACRO_DIM),
  localparam int MV_W         = mv_w(SEARCH_RANGE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       ad_valid,
  input  logic [MACRO_DIM*MACRO_DIM*8-1:0] ad_in,
  output logic                       busy,
  output logic                       done,
  output logic [SAD_W-1:0]           best_sad,
  output logic [MV_W-1:0]            best_mvx,
  output logic [MV_W-1:0]            best_mvy
);

  localparam int COL_W    = col_w(MACRO_DIM);
  localparam int SIDE     = 2 * SEARCH_RANGE;
  localparam int NCAND    = SIDE * SIDE;
  localparam int CNT_W    = $clog2(NCAND + 1);
  localparam int STAGES   = 2;
  localparam int COL_BITS = MACRO_DIM * 8;

  logic [MACRO_DIM-1:0][COL_W-1:0] col_sum;
  logic [SAD_W-1:0]                sad_tot;

  for (genvar c = 0; c < MACRO_DIM; c++) begin : g_col
    sad_col_tree #(.N(MACRO_DIM), .IN_W(8), .OUT_W(COL_W)) u_col (
      .clk   (clk),
      .rst   (rst),
      .in_vec(ad_in[c*COL_BITS +: COL_BITS]),
      .sum_q (col_sum[c])
    );
  end

  sad_col_tree #(.N(MACRO_DIM), .IN_W(COL_W), .OUT_W(SAD_W)) u_tot (
    .clk   (clk),
    .rst   (rst),
    .in_vec(col_sum),
    .sum_q (sad_tot)
  );

  me_state_t         state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [MV_W-1:0]   cmp_x_q, cmp_x_d, cmp_y_q, cmp_y_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [MV_W-1:0]   best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic              accept, last_cmp;

  assign accept   = (state_q == RUN) && ad_valid && !start;
  assign last_cmp = vld_pipe_q[STAGES] && (cmp_x_q == MV_W'(SIDE - 1)) && (cmp_y_q == MV_W'(SIDE - 1));

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    cmp_x_d    = cmp_x_q;
    cmp_y_d    = cmp_y_q;
    best_sad_d = best_sad_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;
    vld_pipe_d = vld_pipe_q;
    if (start) begin
      // start wins over any in-flight compare so an aborted search leaves no trace
      state_d    = RUN;
      in_cnt_d   = '0;
      cmp_x_d    = '0;
      cmp_y_d    = '0;
      best_sad_d = '1;
      vld_pipe_d = '0;
    end else begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
      if (accept) in_cnt_d = in_cnt_q + 1'b1;
      if (vld_pipe_q[STAGES]) begin
        if (sad_tot < best_sad_q) begin
          best_sad_d = sad_tot;
          best_mvx_d = cmp_x_q - MV_W'(SEARCH_RANGE);
          best_mvy_d = cmp_y_q - MV_W'(SEARCH_RANGE);
        end
        if (cmp_x_q == MV_W'(SIDE - 1)) begin
          cmp_x_d = '0;
          cmp_y_d = cmp_y_q + 1'b1;
        end else begin
          cmp_x_d = cmp_x_q + 1'b1;
        end
      end
      case (state_q)
        RUN:     if (accept && (in_cnt_q == CNT_W'(NCAND - 1))) state_d = DRAIN;
        DRAIN:   if (last_cmp) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      cmp_x_q    <= '0;
      cmp_y_q    <= '0;
      best_sad_q <= '1;
      best_mvx_q <= '0;
      best_mvy_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      cmp_x_q    <= cmp_x_d;
      cmp_y_q    <= cmp_y_d;
      best_sad_q <= best_sad_d;
      best_mvx_q <= best_mvx_d;
      best_mvy_q <= best_mvy_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign best_sad = best_sad_q;
  assign best_mvx = best_mvx_q;
  assign best_mvy = best_mvy_q;

endmodule
